// File: rtl/uart_tx_fifo.sv
// UART transmitter with a transmit FIFO and per-frame framing latched at pop.
// Optional parity generation is built when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
  parameter int PAYLOAD_BITS = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int DIV_BITS     = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DIV_BITS-1:0]            divider,
  input  logic [3:0]                     cfg_data_bits,
  input  logic                           cfg_parity_en,
  input  logic                           cfg_parity_odd,
  input  logic                           cfg_stop2,
  input  logic                           wr_valid,
  input  logic [PAYLOAD_BITS-1:0]        wr_data,
  output logic                           wr_ready,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic                           uart_txd,
  output logic                           uart_tx_busy,
  output logic                           tx_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    , S_PARITY = 3'd4
`endif
  } state_t;

  function automatic logic [3:0] eff_bits(input logic [3:0] n);
    if (n == 4'd0 || n > 4'(PAYLOAD_BITS)) return 4'(PAYLOAD_BITS);
    return n;
  endfunction

  logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [LW-1:0]           level;
  logic                    push, pop, fifo_empty;
  logic [PAYLOAD_BITS-1:0] head;
  logic [3:0]              load_bits;

  assign fifo_empty   = (level == '0);
  assign wr_ready     = (level != LW'(FIFO_DEPTH));
  assign push         = wr_valid && wr_ready;
  assign head         = mem[rd_ptr];
  assign load_bits    = eff_bits(cfg_data_bits);
  assign fifo_level   = level;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Frame registers hold the configuration captured when the byte was popped.
  state_t                  state, state_n;
  logic [DIV_BITS-1:0]     bit_cnt, bit_cnt_n, f_div, f_div_n;
  logic [PAYLOAD_BITS-1:0] f_shift, f_shift_n;
  logic [3:0]              f_nbits, f_nbits_n, bit_idx, bit_idx_n;
  logic                    f_stop2, f_stop2_n, stop_idx, stop_idx_n;
  logic                    txd_q, txd_n, done_q, done_n;
  logic                    bit_end, load;

`ifdef UART_TX_PARITY_EN
  function automatic logic [PAYLOAD_BITS-1:0] data_mask(input logic [3:0] nb);
    logic [PAYLOAD_BITS-1:0] m;
    for (int i = 0; i < PAYLOAD_BITS; i++) m[i] = (i < int'(nb));
    return m;
  endfunction

  logic f_par_en, f_par_en_n, f_par_bit, f_par_bit_n;
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = cfg_parity_en ^ cfg_parity_odd;
`endif

  assign bit_end = (bit_cnt == f_div);

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_end ? '0 : bit_cnt + 1'b1;
    f_div_n     = f_div;
    f_shift_n   = f_shift;
    f_nbits_n   = f_nbits;
    f_stop2_n   = f_stop2;
    bit_idx_n   = bit_idx;
    stop_idx_n  = stop_idx;
    txd_n       = txd_q;
    done_n      = 1'b0;
    pop         = 1'b0;
    load        = 1'b0;
`ifdef UART_TX_PARITY_EN
    f_par_en_n  = f_par_en;
    f_par_bit_n = f_par_bit;
`endif
    case (state)
      S_IDLE: begin
        bit_cnt_n = '0;
        txd_n     = 1'b1;
        if (!fifo_empty) load = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_n   = S_DATA;
          bit_idx_n = '0;
          txd_n     = f_shift[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx == f_nbits - 1'b1) begin
`ifdef UART_TX_PARITY_EN
            if (f_par_en) begin
              state_n = S_PARITY;
              txd_n   = f_par_bit;
            end else
`endif
            begin
              state_n    = S_STOP;
              stop_idx_n = 1'b0;
              txd_n      = 1'b1;
            end
          end else begin
            bit_idx_n = bit_idx + 1'b1;
            f_shift_n = f_shift >> 1;
            txd_n     = f_shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_n    = S_STOP;
          stop_idx_n = 1'b0;
          txd_n      = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (f_stop2 && !stop_idx) begin
            stop_idx_n = 1'b1;
          end else begin
            done_n = 1'b1;
            if (!fifo_empty) begin
              load = 1'b1;
            end else begin
              state_n = S_IDLE;
              txd_n   = 1'b1;
            end
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        txd_n   = 1'b1;
      end
    endcase
    // A pop from IDLE or from the end of STOP both start a frame on this edge.
    if (load) begin
      pop       = 1'b1;
      state_n   = S_START;
      bit_cnt_n = '0;
      txd_n     = 1'b0;
      f_div_n   = divider;
      f_shift_n = head;
      f_nbits_n = load_bits;
      f_stop2_n = cfg_stop2;
`ifdef UART_TX_PARITY_EN
      f_par_en_n  = cfg_parity_en;
      f_par_bit_n = ^(head & data_mask(load_bits)) ^ cfg_parity_odd;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      txd_q    <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      bit_idx  <= bit_idx_n;
      stop_idx <= stop_idx_n;
      txd_q    <= txd_n;
      done_q   <= done_n;
    end
  end

  always_ff @(posedge clk) begin
    f_div     <= f_div_n;
    f_shift   <= f_shift_n;
    f_nbits   <= f_nbits_n;
    f_stop2   <= f_stop2_n;
`ifdef UART_TX_PARITY_EN
    f_par_en  <= f_par_en_n;
    f_par_bit <= f_par_bit_n;
`endif
  end

  assign uart_txd     = txd_q;
  assign tx_done      = done_q;
  assign uart_tx_busy = !fifo_empty || (state != S_IDLE);

endmodule
